// File: rtl/big_fv_iter_sched_pkg.sv
// rtl/big_fv_iter_sched_pkg.sv - shared state enum and derived widths for the Big FV iteration scheduler
`include "sys_defs.svh"

package big_fv_iter_sched_pkg;

  localparam int NUM_BANKS_ALL_FV = `Num_Banks_all_FV;
  localparam int MAX_REPLAY       = `Max_replay_Iter;
  localparam int MAX_UPDATE       = `Max_update_Iter;
  localparam int MAX_FV           = `Max_FV_num;

  localparam int REPLAY_IDX_W = $clog2(MAX_REPLAY);
  localparam int UPDATE_IDX_W = $clog2(MAX_UPDATE);
  localparam int REPLAY_CFG_W = REPLAY_IDX_W + 1;
  localparam int UPDATE_CFG_W = UPDATE_IDX_W + 1;
  localparam int FV_W         = $clog2(MAX_FV) + 1;

  localparam logic [REPLAY_CFG_W-1:0] MAX_REPLAY_CFG = REPLAY_CFG_W'(MAX_REPLAY);
  localparam logic [UPDATE_CFG_W-1:0] MAX_UPDATE_CFG = UPDATE_CFG_W'(MAX_UPDATE);
  localparam logic [FV_W-1:0]         MAX_FV_CFG     = FV_W'(MAX_FV);

  typedef enum logic [2:0] {
    IDLE,
    BEGIN,
    STREAM,
    WAIT_UPD,
    ADVANCE,
    DONE
  } sched_state_e;

endpackage

// File: rtl/sys_defs.svh
// rtl/sys_defs.svh - system-wide sizing macros for the Big FV datapath
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define Num_Banks_all_FV 4
`define Max_replay_Iter  4
`define Max_update_Iter  4
`define Max_FV_num       16

`endif

// File: rtl/big_fv_iter_sched.sv
// rtl/big_fv_iter_sched.sv - sequences replay/update iterations across the Big FV bank controllers
`include "sys_defs.svh"

module big_fv_iter_sched
  import big_fv_iter_sched_pkg::*;
#(
  parameter int NUM_BANKS = `Num_Banks_all_FV
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                abort,
  input  logic [$clog2(`Max_replay_Iter):0]   cfg_replay_num,
  input  logic [$clog2(`Max_update_Iter):0]   cfg_update_num,
  input  logic [$clog2(`Max_FV_num):0]        cfg_FV_num,
  input  logic [NUM_BANKS-1:0]                bank_stream_done,
  input  logic                                update_done,
  output logic [$clog2(`Max_replay_Iter)-1:0] Cur_Replay_Iter,
  output logic [$clog2(`Max_update_Iter)-1:0] Cur_Update_Iter,
  output logic [$clog2(`Max_FV_num):0]        FV_num,
  output logic                                stream_begin,
  output logic                                ping_sel,
  output logic                                busy,
  output logic                                run_done,
  output logic                                cfg_err
);

  sched_state_e state, state_n;

  logic [NUM_BANKS-1:0]    sticky;
  logic                    pending;
  logic [REPLAY_CFG_W-1:0] replay_num_q;
  logic [UPDATE_CFG_W-1:0] update_num_q;
  logic                    cfg_ok;
  logic                    all_done;
  logic                    last_replay;
  logic                    last_update;

  always_comb begin
    cfg_ok = (cfg_replay_num != '0) && (cfg_replay_num <= MAX_REPLAY_CFG) &&
             (cfg_update_num != '0) && (cfg_update_num <= MAX_UPDATE_CFG) &&
             (cfg_FV_num != '0)     && (cfg_FV_num <= MAX_FV_CFG);
    all_done    = &(sticky | bank_stream_done);
    last_replay = (({1'b0, Cur_Replay_Iter} + REPLAY_CFG_W'(1)) == replay_num_q);
    last_update = (({1'b0, Cur_Update_Iter} + UPDATE_CFG_W'(1)) == update_num_q);

    state_n = state;
    case (state)
      IDLE:     if (start && cfg_ok) state_n = BEGIN;
      BEGIN:    state_n = STREAM;
      STREAM:   if (all_done) state_n = WAIT_UPD;
      WAIT_UPD: if (update_done || pending) state_n = ADVANCE;
      ADVANCE:  state_n = (last_replay && last_update) ? DONE : BEGIN;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    // Cancel wins over every other transition once a run is underway.
    if (abort && (state != IDLE)) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      sticky          <= '0;
      pending         <= 1'b0;
      replay_num_q    <= '0;
      update_num_q    <= '0;
      Cur_Replay_Iter <= '0;
      Cur_Update_Iter <= '0;
      FV_num          <= '0;
      stream_begin    <= 1'b0;
      ping_sel        <= 1'b0;
      busy            <= 1'b0;
      run_done        <= 1'b0;
      cfg_err         <= 1'b0;
    end else begin
      state        <= state_n;
      stream_begin <= (state_n == BEGIN);
      busy         <= (state_n != IDLE);
      run_done     <= (state_n == DONE);
      cfg_err      <= (state == IDLE) && start && !cfg_ok;

      case (state)
        IDLE: begin
          if (start && cfg_ok) begin
            replay_num_q    <= cfg_replay_num;
            update_num_q    <= cfg_update_num;
            FV_num          <= cfg_FV_num;
            Cur_Replay_Iter <= '0;
            Cur_Update_Iter <= '0;
          end
        end
        BEGIN: begin
          sticky  <= '0;
          pending <= 1'b0;
        end
        STREAM: begin
          // An early update completion is remembered so WAIT_UPD cannot stall on it.
          sticky  <= sticky | bank_stream_done;
          pending <= pending | update_done;
        end
        ADVANCE: begin
          if (!abort) begin
            if (!last_replay) begin
              Cur_Replay_Iter <= Cur_Replay_Iter + REPLAY_IDX_W'(1);
            end else begin
              Cur_Replay_Iter <= '0;
              ping_sel        <= ~ping_sel;
              if (!last_update) Cur_Update_Iter <= Cur_Update_Iter + UPDATE_IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_big_fv_iter_sched.sv
// tb/tb_big_fv_iter_sched.sv - randomized self-checking bench for big_fv_iter_sched
module tb_big_fv_iter_sched;
  import big_fv_iter_sched_pkg::*;

  localparam int NB = NUM_BANKS_ALL_FV;

  logic                    clk = 1'b0;
  logic                    reset, start, abort, update_done;
  logic [REPLAY_CFG_W-1:0] cfg_replay_num;
  logic [UPDATE_CFG_W-1:0] cfg_update_num;
  logic [FV_W-1:0]         cfg_FV_num;
  logic [NB-1:0]           bank_stream_done;
  logic [REPLAY_IDX_W-1:0] Cur_Replay_Iter;
  logic [UPDATE_IDX_W-1:0] Cur_Update_Iter;
  logic [FV_W-1:0]         FV_num;
  logic                    stream_begin, ping_sel, busy, run_done, cfg_err;

  int errors = 0;
  int checks = 0;
  int fix_a[NB];
  int fix_b;

  always #5 clk = ~clk;

  big_fv_iter_sched #(.NUM_BANKS(NB)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_replay_num(cfg_replay_num), .cfg_update_num(cfg_update_num), .cfg_FV_num(cfg_FV_num),
    .bank_stream_done(bank_stream_done), .update_done(update_done),
    .Cur_Replay_Iter(Cur_Replay_Iter), .Cur_Update_Iter(Cur_Update_Iter), .FV_num(FV_num),
    .stream_begin(stream_begin), .ping_sel(ping_sel), .busy(busy),
    .run_done(run_done), .cfg_err(cfg_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0;
    abort = 1'b0;
    update_done = 1'b0;
    bank_stream_done = '0;
  endtask

  // Timing model: banks pulse at k+a[i], update at k+b (k = stream_begin cycle).
  // The next stream_begin (or run_done) follows at k + max(max(a)+1, b) + 2.
  // mode 0 = complete run, 1 = abort in STREAM of stream ev, 2 = reset in WAIT_UPD of stream ev.
  task automatic run_case(input string name, input int r, input int u, input int fv,
                          input int mode, input int ev);
    int t, k, next_k, done_k, end_k, abort_k, reset_k, big_a, hold, n, b, rr, uu;
    int a[NB];
    logic p0, pe;
    bit fin, last;
    p0 = ping_sel;
    rr = 0; uu = 0; n = 0; t = 0; k = -1000; b = -1;
    next_k = 0; done_k = -1; end_k = -1; abort_k = -1; reset_k = -1;
    fin = 1'b0; last = 1'b0;
    for (int i = 0; i < NB; i++) a[i] = -1;
    cfg_replay_num = REPLAY_CFG_W'(r);
    cfg_update_num = UPDATE_CFG_W'(u);
    cfg_FV_num     = FV_W'(fv);
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_replay_num = REPLAY_CFG_W'($urandom);
    cfg_update_num = UPDATE_CFG_W'($urandom);
    cfg_FV_num     = FV_W'($urandom);
    while (!fin) begin
      if (t == end_k) begin
        checks++;
        if (busy !== 1'b0 || run_done !== 1'b0 || stream_begin !== 1'b0) begin
          errors++;
          $display("FAIL %s end_flags: busy=%b run_done=%b stream_begin=%b, required all 0", name, busy, run_done, stream_begin);
        end
        if (mode == 1) begin
          pe = p0 ^ uu[0];
          checks++;
          if (Cur_Replay_Iter !== REPLAY_IDX_W'(rr) || Cur_Update_Iter !== UPDATE_IDX_W'(uu) || ping_sel !== pe) begin
            errors++;
            $display("FAIL %s abort_hold: replay=%0d update=%0d ping=%b, required %0d %0d %b", name, Cur_Replay_Iter, Cur_Update_Iter, ping_sel, rr, uu, pe);
          end
        end
        if (mode == 2) begin
          checks++;
          if (Cur_Replay_Iter !== '0 || Cur_Update_Iter !== '0 || FV_num !== '0 || ping_sel !== 1'b0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL %s reset_clear: replay=%0d update=%0d fv=%0d ping=%b cfg_err=%b, required all 0", name, Cur_Replay_Iter, Cur_Update_Iter, FV_num, ping_sel, cfg_err);
          end
        end
        fin = 1'b1;
      end else begin
        checks++;
        if (stream_begin !== (t == next_k)) begin
          errors++;
          $display("FAIL %s stream_begin@%0d: got %b, required %b", name, t, stream_begin, (t == next_k));
        end
        checks++;
        if (run_done !== (t == done_k)) begin
          errors++;
          $display("FAIL %s run_done@%0d: got %b, required %b", name, t, run_done, (t == done_k));
        end
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy@%0d: got %b, required 1", name, t, busy);
        end
        if (t == next_k) begin
          pe = p0 ^ uu[0];
          checks++;
          if (Cur_Replay_Iter !== REPLAY_IDX_W'(rr) || Cur_Update_Iter !== UPDATE_IDX_W'(uu) ||
              ping_sel !== pe || FV_num !== FV_W'(fv)) begin
            errors++;
            $display("FAIL %s stream%0d_state: replay=%0d update=%0d ping=%b fv=%0d, required %0d %0d %b %0d",
                     name, n, Cur_Replay_Iter, Cur_Update_Iter, ping_sel, FV_num, rr, uu, pe, fv);
          end
          k = t;
          next_k = -1;
          if (mode == 1 && n == ev) begin
            for (int i = 0; i < NB; i++) a[i] = -1;
            b = -1;
            abort_k = k + 1;
            end_k = k + 2;
          end else begin
            big_a = 0;
            for (int i = 0; i < NB; i++) begin
              a[i] = (fix_a[i] != 0) ? fix_a[i] : int'($urandom_range(1, 12));
              if (a[i] > big_a) big_a = a[i];
            end
            b = (fix_b != 0) ? fix_b : int'($urandom_range(1, 15));
            if (mode == 2 && n == ev) begin
              b = big_a + 5;
              reset_k = k + big_a + 1;
              end_k = reset_k + 1;
            end else begin
              hold = ((big_a + 1 > b) ? big_a + 1 : b) + 2;
              if (rr < r - 1) rr++;
              else begin
                rr = 0;
                if (uu == u - 1) last = 1'b1;
                else uu++;
              end
              if (last) begin
                done_k = k + hold;
                end_k = done_k + 1;
              end else begin
                next_k = k + hold;
              end
            end
          end
          n++;
        end
        if (t == done_k) begin
          pe = p0 ^ u[0];
          checks++;
          if (Cur_Replay_Iter !== '0 || Cur_Update_Iter !== UPDATE_IDX_W'(u - 1) || ping_sel !== pe || FV_num !== FV_W'(fv)) begin
            errors++;
            $display("FAIL %s final_state: replay=%0d update=%0d ping=%b fv=%0d, required 0 %0d %b %0d",
                     name, Cur_Replay_Iter, Cur_Update_Iter, ping_sel, FV_num, u - 1, pe, fv);
          end
        end
        for (int i = 0; i < NB; i++) bank_stream_done[i] = (a[i] > 0) && (t == k + a[i]);
        update_done = (b > 0) && (t == k + b);
        abort = (t == abort_k);
        reset = !(t == reset_k);
        start = ($urandom_range(0, 7) == 0);
        if (t > 3000) begin
          checks++;
          errors++;
          $display("FAIL %s timeout: cycle %0d, required completion by 3000", name, t);
          fin = 1'b1;
        end else begin
          step();
          t++;
        end
      end
    end
    idle_inputs();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    cfg_replay_num = REPLAY_CFG_W'(1);
    cfg_update_num = UPDATE_CFG_W'(1);
    cfg_FV_num = FV_W'(1);
    step();
    step();
    checks++;
    if (busy !== 1'b0 || stream_begin !== 1'b0 || run_done !== 1'b0 || cfg_err !== 1'b0 || ping_sel !== 1'b0 ||
        Cur_Replay_Iter !== '0 || Cur_Update_Iter !== '0 || FV_num !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b sb=%b rd=%b ce=%b ping=%b r=%0d u=%0d fv=%0d, required all 0",
               busy, stream_begin, run_done, cfg_err, ping_sel, Cur_Replay_Iter, Cur_Update_Iter, FV_num);
    end
    idle_inputs();
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    for (int i = 0; i < NB; i++) fix_a[i] = 2;
    fix_b = 4;
    run_case("basic_r2u1", 2, 1, 4, 0, -1);
  endtask

  task automatic test_staggered();
    fix_a[0] = 3; fix_a[1] = 5; fix_a[2] = 7; fix_a[3] = 9;
    fix_b = 1;
    run_case("staggered", 1, 1, 8, 0, -1);
  endtask

  task automatic test_early_update();
    fix_a[0] = 4; fix_a[1] = 4; fix_a[2] = 6; fix_a[3] = 8;
    fix_b = 2;
    run_case("early_update", 2, 1, 3, 0, -1);
  endtask

  task automatic test_cfg_err();
    logic [REPLAY_CFG_W-1:0] rv[4];
    logic [UPDATE_CFG_W-1:0] uv[4];
    logic [FV_W-1:0]         fv[4];
    rv[0] = 0;              uv[0] = 1;              fv[0] = 4;
    rv[1] = 2;              uv[1] = 1;              fv[1] = MAX_FV_CFG + 1'b1;
    rv[2] = 1;              uv[2] = MAX_UPDATE_CFG + 1'b1; fv[2] = 2;
    rv[3] = MAX_REPLAY_CFG + 1'b1; uv[3] = 0;       fv[3] = 0;
    for (int c = 0; c < 4; c++) begin
      cfg_replay_num = rv[c];
      cfg_update_num = uv[c];
      cfg_FV_num = fv[c];
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || stream_begin !== 1'b0) begin
        errors++;
        $display("FAIL cfg_err_case%0d: cfg_err=%b busy=%b sb=%b, required 1 0 0", c, cfg_err, busy, stream_begin);
      end
      step();
      checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0 || stream_begin !== 1'b0) begin
        errors++;
        $display("FAIL cfg_err_pulse%0d: cfg_err=%b busy=%b sb=%b, required 0 0 0", c, cfg_err, busy, stream_begin);
      end
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < NB; i++) fix_a[i] = 0;
    fix_b = 0;
    run_case("abort_r3u2", 3, 2, 5, 1, 1);
    run_case("after_abort", 3, 2, 5, 0, -1);
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < NB; i++) fix_a[i] = 0;
    fix_b = 0;
    run_case("reset_wait_upd", 2, 2, 6, 2, 1);
    run_case("after_reset_r1u3", 1, 3, 7, 0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < NB; i++) fix_a[i] = 0;
    fix_b = 0;
    for (int it = 0; it < 8; it++) begin
      run_case("random", int'($urandom_range(1, MAX_REPLAY)), int'($urandom_range(1, MAX_UPDATE)),
               int'($urandom_range(1, MAX_FV)), 0, -1);
    end
  endtask

  initial begin
    for (int i = 0; i < NB; i++) fix_a[i] = 0;
    fix_b = 0;
    idle_inputs();
    reset = 1'b0;
    cfg_replay_num = '0;
    cfg_update_num = '0;
    cfg_FV_num = '0;
    test_reset();
    test_basic();
    test_staggered();
    test_early_update();
    test_cfg_err();
    test_abort();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/big_fv_iter_sched.md
BIG_FV_ITER_SCHED -- requirements
Module: big_fv_iter_sched

Interface
REQ-001 SHALL have parameter NUM_BANKS, default `Num_Banks_all_FV, meaning the number of Big FV bank controllers sequenced.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit, a run-request pulse.
REQ-005 SHALL have port abort, input, 1 bit, a synchronous run-cancel.
REQ-006 SHALL have port cfg_replay_num, input, $clog2(`Max_replay_Iter)+1 bits, the replay iterations per update iteration.
REQ-007 SHALL have port cfg_update_num, input, $clog2(`Max_update_Iter)+1 bits, the update iterations per run.
REQ-008 SHALL have port cfg_FV_num, input, $clog2(`Max_FV_num)+1 bits, the FV count per stream.
REQ-009 SHALL have port bank_stream_done, input, NUM_BANKS bits, per-bank done pulses for the current stream.
REQ-010 SHALL have port update_done, input, 1 bit, a pulse marking edge-PE update completion for the current replay.
REQ-011 SHALL have port Cur_Replay_Iter, output, $clog2(`Max_replay_Iter) bits, the current replay index.
REQ-012 SHALL have port Cur_Update_Iter, output, $clog2(`Max_update_Iter) bits, the current update index.
REQ-013 SHALL have port FV_num, output, $clog2(`Max_FV_num)+1 bits, the latched cfg_FV_num.
REQ-014 SHALL have port stream_begin, output, 1 bit, a one-cycle stream start pulse to all banks.
REQ-015 SHALL have port ping_sel, output, 1 bit, selecting which buffer is currently the ping buffer.
REQ-016 SHALL have ports busy, run_done and cfg_err, each output, 1 bit: busy is the not-IDLE flag; run_done and cfg_err are one-cycle pulses.

Function
REQ-017 SHALL register all outputs.
REQ-018 SHALL implement FSM states IDLE, BEGIN, STREAM, WAIT_UPD, ADVANCE and DONE.
REQ-019 IDLE: start=1 with valid config SHALL latch all three cfg_* values and zero both iteration counters; the next state is BEGIN.
REQ-020 Config is invalid when any cfg_* is 0 or exceeds its `Max_*; in that case the block SHALL stay in IDLE and pulse cfg_err for one cycle.
REQ-021 BEGIN SHALL last exactly one cycle with stream_begin=1, clear the sticky done bits and the pending-update flag, and then go to STREAM.
REQ-022 stream_begin SHALL be high in the cycle immediately after start is sampled, i.e. 1-cycle latency.
REQ-023 STREAM SHALL OR bank_stream_done into a sticky NUM_BANKS-bit register, and SHALL exit to WAIT_UPD on the edge where (sticky | bank_stream_done) is all ones.
REQ-024 update_done arriving in STREAM SHALL set the pending flag rather than be dropped.
REQ-025 WAIT_UPD SHALL go to ADVANCE on update_done=1 or pending=1; if both conditions arrive on the same edge as the STREAM exit, WAIT_UPD still lasts one cycle.
REQ-026 ADVANCE when Cur_Replay_Iter < cfg_replay_num-1 SHALL increment Cur_Replay_Iter and go to BEGIN.
REQ-027 ADVANCE when Cur_Replay_Iter = cfg_replay_num-1 SHALL wrap Cur_Replay_Iter to 0 and toggle ping_sel; it then goes to DONE if Cur_Update_Iter = cfg_update_num-1, otherwise increments Cur_Update_Iter and goes to BEGIN.
REQ-028 DONE SHALL pulse run_done for one cycle and then go to IDLE, holding the final counter values.
REQ-029 start outside IDLE SHALL be ignored, and cfg_* changes after latching SHALL have no effect.
REQ-030 abort=1 in any non-IDLE state SHALL go to IDLE on the next edge without run_done; counters and ping_sel keep their values; abort has priority over all other transitions.
REQ-031 bank_stream_done and update_done outside STREAM/WAIT_UPD SHALL be ignored.
REQ-032 Counters SHALL never exceed the configured value minus 1.

Reset
REQ-033 reset=0 at an edge SHALL force IDLE and zero every output, ping_sel, the counters, the sticky bits and the pending flag, including mid-run.
REQ-034 reset SHALL take priority over abort and start.

Structure
REQ-035 The state enum SHALL live in the shared package.
REQ-036 Widths SHALL derive from the `Num_Banks_all_FV, `Max_replay_Iter, `Max_update_Iter and `Max_FV_num macros in sys_defs.svh.
REQ-037 SHALL be a single module with no sub-module; the instantiating level drives the wrapper's Cur_Replay_Iter, Cur_Update_Iter, FV_num and stream_begin ports from these outputs.

Verification
REQ-038 Run R=2, U=1, FV=4, NUM_BANKS=4 with all banks done at once and then update_done -> 2 stream_begin pulses; Cur_Replay_Iter 0 then 1; ping_sel toggles once; run_done once.
REQ-039 Banks finish on different cycles (bank0 at +3, bank3 at +9) -> WAIT_UPD is entered only on the edge after bank3's pulse.
REQ-040 update_done during STREAM before all banks are done -> after the final bank done, one WAIT_UPD cycle, then ADVANCE with no hang.
REQ-041 start with cfg_replay_num=0, or cfg_FV_num=`Max_FV_num+1 -> cfg_err pulse, busy stays 0, no stream_begin.
REQ-042 abort in STREAM of R=3, U=2 at replay 1 -> IDLE next cycle, no run_done; a following start restarts at replay 0, update 0.
REQ-043 reset=0 in WAIT_UPD -> all outputs 0 next cycle; a second start with R=1, U=3 gives 3 stream_begin pulses and ping_sel toggling 3 times.
